dff4_enable_reg: RTL and testbench
==================================

// Module: dff4_enable_reg
// PURPOSE
//   Parallel register of WIDTH D flip-flops with a shared load enable and a synchronous active-low reset.
//   Captures D on the rising clock edge when En is high, otherwise holds its value.
//   Leaf storage element for datapaths and register files; default width is a 4-bit nibble.
// PARAMETERS
//   WIDTH        4      data width in bits; legal range >= 1
//   RESET_VALUE  '0     value loaded into Q during reset; WIDTH bits wide
// PORTS
//   clk      in   1      single clock; all state updates on its rising edge
//   reset    in   1      synchronous, active-low reset; sampled only at rising clk
//   En       in   1      load enable, active-high
//   D        in   WIDTH  data input
//   Q        out  WIDTH  registered output
//   Q_chg    out  1      change pulse; present only with DFF4_CHANGE_FLAG_EN
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low.
//   - At each rising clk edge, in priority order:
//       reset==0        : Q <= RESET_VALUE
//       reset==1, En==1 : Q <= D
//       reset==1, En==0 : Q holds
//   - Reset overrides En. reset low with En high still loads RESET_VALUE.
//   - Latency: a loaded D appears on Q exactly one edge after capture.
//   - Q is driven only by flops. There is no combinational path from D, En or reset to Q.
//   - Q does not change between edges. An asynchronous change of reset has no effect until the next edge.
//   - If D changes on the same edge at which it is sampled, the value present before the edge is captured.
//   - While En==0, D is ignored, including X/Z values.
//   - If En is X/Z while reset==1, the result is undefined and flagged in simulation. Not a legal input.
//   - Q is undefined after power-up until the first edge with reset==0, or the first edge with En==1.
//   - Reset asserted mid-stream: the next edge yields RESET_VALUE. The first load after release takes effect on the edge at which reset==1 and En==1.
// CONFIGURATION
//   - Macro DFF4_CHANGE_FLAG_EN.
//   - Defined: adds output Q_chg, a registered signal set on every edge.
//       Q_chg is 1 when that edge altered Q (the load value differs from the old Q); otherwise 0.
//       Reset drives Q_chg to 0.
//       Q_chg has the same one-edge latency as Q.
//   - Undefined: Q_chg and its logic are removed, and the port list is exactly clk, reset, En, D, Q.
// STRUCTURE
//   - Package dff4_pkg holds:
//       DFF4_DEFAULT_WIDTH = 4
//       typedef logic [DFF4_DEFAULT_WIDTH-1:0] dff4_word_t
//       DFF4_DEFAULT_RESET = '0
//   - Sub-module dff_bit_en: a 1-bit flop with enable and synchronous active-low reset, plus a per-bit reset value.
//   - Top level instantiates WIDTH copies via generate. Change-flag logic lives in the top level under the macro.
// TESTING
//   1. Reset: reset=0 with En=0 and D=4'b0000 at one edge -> Q=4'b0000 (Q_chg=0) after that edge.
//   2. Load: reset=1, En=1, D=4'b0001 -> Q=4'b0001 after the next edge.
//      Then D=4'b1010 -> Q=4'b1010; Q_chg=1 on each change.
//   3. Hold: En=0 with D stepping 4'b1010 -> 4'b0010 over 3+ edges -> Q stays 4'b1010, Q_chg=0.
//   4. Re-enable: En=1, D=4'b0100 -> Q=4'b0100. Then D=4'b1111 held 4 edges -> Q=4'b1111, Q_chg=1 only once.
//   5. Priority: Q=4'b1111, reset=0 with En=1 and D=4'b0101 -> Q=4'b0000 at the edge. Release with En=1 -> Q=4'b0101 on the following edge.
//   6. Timing: toggle D and reset between edges with En=1 -> Q changes only at rising clk. Repeat with WIDTH=8 and RESET_VALUE=8'hA5.

Source files
------------

// File: rtl/dff4_pkg.sv
// dff4_pkg: shared definitions for the dff4 register slice.
//   DFF4_DEFAULT_WIDTH : default register width (a nibble)
//   dff4_word_t        : word type at the default width
//   DFF4_DEFAULT_RESET : default reset value for the default word
package dff4_pkg;

    localparam int DFF4_DEFAULT_WIDTH = 4;

    typedef logic [DFF4_DEFAULT_WIDTH-1:0] dff4_word_t;

    localparam dff4_word_t DFF4_DEFAULT_RESET = '0;

endpackage : dff4_pkg

// File: rtl/dff_bit_en.sv
// dff_bit_en: single storage bit with load enable and synchronous active-low
// reset. The reset value is set per instance so a parallel register can have
// any reset pattern.
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous active-low reset, overrides en
//   en    in  1  load enable, active-high
//   d     in  1  data input
//   q     out 1  registered output
module dff_bit_en #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (!reset)
            q <= RST_VAL;
        else if (en)
            q <= d;
    end

endmodule : dff_bit_en

// File: rtl/dff4_enable_reg.sv
// dff4_enable_reg: WIDTH-bit parallel register with shared load enable and
// synchronous active-low reset. Built from WIDTH dff_bit_en instances.
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous active-low reset, loads RESET_VALUE
//   En     in  1      load enable, active-high
//   D      in  WIDTH  data input
//   Q      out WIDTH  registered output
//   Q_chg  out 1      registered "this edge altered Q" pulse
//                     (only when DFF4_CHANGE_FLAG_EN is defined)
// Optional feature macro: DFF4_CHANGE_FLAG_EN
module dff4_enable_reg
    import dff4_pkg::*;
#(
    parameter int               WIDTH       = DFF4_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DFF4_DEFAULT_RESET)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
`ifdef DFF4_CHANGE_FLAG_EN
    output logic [WIDTH-1:0] Q,
    output logic             Q_chg
`else
    output logic [WIDTH-1:0] Q
`endif
);

    wire [WIDTH-1:0] q_w;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        dff_bit_en #(
            .RST_VAL (RESET_VALUE[i])
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .en    (En),
            .d     (D[i]),
            .q     (q_w[i])
        );
    end

    assign Q = q_w;

`ifdef DFF4_CHANGE_FLAG_EN
    // Compares the load value against the pre-edge Q, so the pulse lines up
    // with the edge that actually changed Q.
    always_ff @(posedge clk) begin
        if (!reset)
            Q_chg <= 1'b0;
        else
            Q_chg <= En && (D != q_w);
    end
`endif

    // An unknown enable out of reset makes the load/hold decision meaningless.
    a_en_known: assert property (@(posedge clk) reset |-> !$isunknown(En));

endmodule : dff4_enable_reg

// File: tb/tb_dff4_enable_reg.sv
module tb_dff4_enable_reg;

    typedef struct {
        logic [3:0] q4;
        logic       chg;
        logic [7:0] q8;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [3:0] d4, q4;
    logic [7:0] d8, q8;
    logic       chg4, chg8;

    int checks = 0;
    int errors = 0;

    exp_t       sb[$];
    logic [3:0] last_q4;
    logic [7:0] last_q8;

    always #5 clk = ~clk;

    dff4_enable_reg u_dut4 (
        .clk   (clk),
        .reset (reset),
        .En    (en),
        .D     (d4),
`ifdef DFF4_CHANGE_FLAG_EN
        .Q_chg (chg4),
`endif
        .Q     (q4)
    );

    dff4_enable_reg #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) u_dut8 (
        .clk   (clk),
        .reset (reset),
        .En    (en),
        .D     (d8),
`ifdef DFF4_CHANGE_FLAG_EN
        .Q_chg (chg8),
`endif
        .Q     (q8)
    );

`ifndef DFF4_CHANGE_FLAG_EN
    assign chg4 = 1'b0;
    assign chg8 = 1'b0;
`endif

    // Monitor: one registered result per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (q4 !== e.q4) begin
                    errors++;
                    $display("FAIL q4: got %b want %b at %0t", q4, e.q4, $time);
                end
                checks++;
                if (q8 !== e.q8) begin
                    errors++;
                    $display("FAIL q8: got %h want %h at %0t", q8, e.q8, $time);
                end
`ifdef DFF4_CHANGE_FLAG_EN
                checks++;
                if (chg4 !== e.chg) begin
                    errors++;
                    $display("FAIL q_chg: got %b want %b at %0t", chg4, e.chg, $time);
                end
`endif
            end
        end
    end

    // Drive one edge's worth of inputs and the hand-computed result after that edge.
    // glitch=1 wiggles reset and D between edges and checks Q did not move.
    task automatic step(input logic r, input logic e, input logic [3:0] vd4,
                        input logic [7:0] vd8, input logic [3:0] xq4,
                        input logic xchg, input logic [7:0] xq8, input bit glitch);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; d4 = vd4; d8 = vd8;
        x.q4 = xq4; x.chg = xchg; x.q8 = xq8;
        sb.push_back(x);
        if (glitch) begin
            #1;
            reset = ~r; d4 = ~vd4; d8 = ~vd8;
            #1;
            checks++;
            if (q4 !== last_q4) begin
                errors++;
                $display("FAIL midcycle_q4: got %b want %b at %0t", q4, last_q4, $time);
            end
            checks++;
            if (q8 !== last_q8) begin
                errors++;
                $display("FAIL midcycle_q8: got %h want %h at %0t", q8, last_q8, $time);
            end
            #1;
            reset = r; d4 = vd4; d8 = vd8;
        end
        last_q4 = xq4;
        last_q8 = xq8;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; d4 = 4'h0; d8 = 8'h00;
        last_q4 = 4'h0; last_q8 = 8'h00;

        // reset
        step(0, 0, 4'b0000, 8'h00, 4'b0000, 0, 8'hA5, 0);
        // load
        step(1, 1, 4'b0001, 8'h11, 4'b0001, 1, 8'h11, 0);
        step(1, 1, 4'b1010, 8'h3C, 4'b1010, 1, 8'h3C, 0);
        // hold: D ignored while En low
        step(1, 0, 4'b1010, 8'hFF, 4'b1010, 0, 8'h3C, 0);
        step(1, 0, 4'b0110, 8'h00, 4'b1010, 0, 8'h3C, 0);
        step(1, 0, 4'b0010, 8'h55, 4'b1010, 0, 8'h3C, 0);
        // re-enable, then same value held: change flag only once
        step(1, 1, 4'b0100, 8'h44, 4'b0100, 1, 8'h44, 0);
        step(1, 1, 4'b1111, 8'hF0, 4'b1111, 1, 8'hF0, 0);
        step(1, 1, 4'b1111, 8'hF0, 4'b1111, 0, 8'hF0, 0);
        step(1, 1, 4'b1111, 8'hF0, 4'b1111, 0, 8'hF0, 0);
        step(1, 1, 4'b1111, 8'hF0, 4'b1111, 0, 8'hF0, 0);
        // priority: reset beats En, release loads on the next edge
        step(0, 1, 4'b0101, 8'h5A, 4'b0000, 0, 8'hA5, 0);
        step(1, 1, 4'b0101, 8'h5A, 4'b0101, 1, 8'h5A, 0);
        // timing: inputs wiggle between edges, Q moves only at the edge
        step(1, 1, 4'b0011, 8'h33, 4'b0011, 1, 8'h33, 1);
        step(0, 1, 4'b1001, 8'h99, 4'b0000, 0, 8'hA5, 1);
        // load of a value equal to the current Q: no change pulse
        step(1, 1, 4'b0000, 8'hA5, 4'b0000, 0, 8'hA5, 1);
        step(1, 1, 4'b0111, 8'h7E, 4'b0111, 1, 8'h7E, 1);
        step(1, 0, 4'b1000, 8'h81, 4'b0111, 0, 8'h7E, 1);

        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule : tb_dff4_enable_reg
